palette_editor: RTL and testbench
=================================

// Module: palette_editor
// PURPOSE
//  Editor/writer for the 16-entry, 24-bit colour palette that the colour selector reads.
//  Steps through palette entries and loads the selected entry from palette RAM.
//  User adjusts the R/G/B channels, then commits the result back to RAM.
//  Sits between the debounced button pulses and the palette RAM write port.
// PARAMETERS
//  ADDR_W   4   palette index width; DEPTH = 2**ADDR_W entries (16)
//  STEP     8   amount added/subtracted per inc/dec pulse, per 8-bit channel
// PORTS
//  clk           in   1   single clock; all state on posedge clk
//  reset         in   1   asynchronous, active-high reset
//  next_entry    in   1   1-cycle pulse: select next palette index
//  prev_entry    in   1   1-cycle pulse: select previous palette index
//  chan_next     in   1   1-cycle pulse: cycle edited channel R->G->B->R
//  inc           in   1   1-cycle pulse: selected channel += STEP (saturating)
//  dec           in   1   1-cycle pulse: selected channel -= STEP (saturating)
//  commit        in   1   1-cycle pulse: write edit_color into the current entry
//  ram_rdata     in   24  palette RAM read data, valid 1 clk after ram_addr
//  ram_addr      out  4   palette RAM address, always equal to entry_idx
//  ram_wdata     out  24  palette RAM write data (= edit_color)
//  ram_wren      out  1   palette RAM write enable, 1-cycle pulse
//  entry_idx     out  4   current palette index
//  edit_color    out  24  working colour {R[23:16],G[15:8],B[7:0]}
//  chan          out  2   edited channel: 0=R, 1=G, 2=B (3 is never driven)
//  dirty         out  1   edit_color differs from the last loaded/committed value
//  busy          out  1   high in any state other than EDIT; inputs are ignored while high
// BEHAVIOUR
//  Reset values: state=LOAD_REQ, entry_idx=0, edit_color=0, chan=0, dirty=0,
//   ram_wren=0, busy=1. A reset mid-write aborts it, and ram_wren drops immediately.
//  FSM states: LOAD_REQ -> LOAD_CAP -> EDIT; EDIT -> WRITE -> EDIT;
//   EDIT -> LOAD_REQ on an index change.
//  LOAD_REQ: ram_addr=entry_idx is presented for 1 cycle.
//  LOAD_CAP: edit_color<=ram_rdata and dirty<=0. Load latency is 2 clks from the index change to EDIT.
//  EDIT accepts one action per cycle, in this priority order:
//   1. commit
//   2. next/prev
//   3. chan_next
//   4. inc/dec
//  Conflicting inputs: next+prev together are ignored, and so are inc+dec together.
//  Index wrap: next at 15 goes to 0; prev at 0 goes to 15.
//  Index change: entry_idx updates, go to LOAD_REQ. Uncommitted edits are discarded (see CONFIGURATION).
//  inc: ch = min(ch+STEP, 255), computed 9 bits wide. dec: ch = max(ch-STEP, 0). Other channels unchanged.
//  dirty<=1 only when the channel value actually changes; a saturated inc/dec leaves dirty unchanged.
//  commit: go to WRITE. WRITE drives ram_wren=1 for exactly 1 cycle,
//   with ram_wdata=edit_color and ram_addr=entry_idx. Then dirty<=0, return to EDIT.
//  commit is allowed even when dirty=0 (the same value is rewritten).
//  Pulses arriving while busy=1 are dropped, not queued.
// CONFIGURATION
//  PALETTE_AUTOCOMMIT_EN defined: next/prev in EDIT with dirty=1 first passes through WRITE
//   for the current index, storing the edit, then updates entry_idx and goes to LOAD_REQ.
//   This adds 1 cycle; busy stays high throughout.
//  PALETTE_AUTOCOMMIT_EN undefined: next/prev always discards the edit; no write is issued.
// TESTING
//  1 RAM preloaded with entry k = 24'h111111*k; release reset -> after 2 clks busy=0,
//    entry_idx=0, edit_color=24'h000000.
//  2 prev at idx 0 -> entry_idx=15, edit_color=24'hFFFFFF. Then next -> idx 0 (wrap both ways).
//  3 At idx 15, chan=R: inc -> R stays 8'hFF, dirty=0. dec x2 -> R=8'hEF, dirty=1.
//    chan_next x3 -> chan back to 0.
//  4 At idx 2 (24'h222222), chan=G, inc, commit -> ram_wren=1 for 1 clk, addr=2,
//    wdata=24'h222A22, dirty=0. Re-entering idx 2 reloads 24'h222A22.
//  5 Same cycle: inc+dec -> no change. commit+next -> write occurs, idx unchanged.
//    Reset asserted during WRITE -> ram_wren=0 immediately, idx=0.
//  6 Dirty edit, then next: without the macro, no ram_wren and the entry is unchanged.
//    With PALETTE_AUTOCOMMIT_EN, one ram_wren to the old idx, then load of idx+1.

Source files
------------

// File: rtl/palette_editor_if.sv
// ============================================================================
//  Module      : palette_editor_if
//  Description : Button-pulse and palette-RAM bundle for palette_editor.
//                master = pulse source / RAM side, slave = the editor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface palette_editor_if #(
  parameter int ADDR_W = 4
);
  // Debounced one-cycle button pulses
  logic              next_entry;
  logic              prev_entry;
  logic              chan_next;
  logic              inc;
  logic              dec;
  logic              commit;
  // Palette RAM port
  logic [23:0]       ram_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [23:0]       ram_wdata;
  logic              ram_wren;
  // Editor status
  logic [ADDR_W-1:0] entry_idx;
  logic [23:0]       edit_color;
  logic [1:0]        chan;
  logic              dirty;
  logic              busy;

  modport master (
    output next_entry, prev_entry, chan_next, inc, dec, commit, ram_rdata,
    input  ram_addr, ram_wdata, ram_wren, entry_idx, edit_color, chan, dirty, busy
  );

  modport slave (
    input  next_entry, prev_entry, chan_next, inc, dec, commit, ram_rdata,
    output ram_addr, ram_wdata, ram_wren, entry_idx, edit_color, chan, dirty, busy
  );
endinterface

`default_nettype wire

// File: rtl/palette_editor.sv
// ============================================================================
//  Module      : palette_editor
//  Description : Steps through a 2**ADDR_W entry, 24-bit colour palette,
//                loads the selected entry, lets the user adjust R/G/B with
//                saturating STEP increments, and writes it back on commit.
//                Optional macro PALETTE_AUTOCOMMIT_EN: a dirty edit is written
//                back automatically before moving to another entry.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module palette_editor #(
  parameter int ADDR_W = 4,
  parameter int STEP   = 8
) (
  input  wire logic        clk,
  input  wire logic        reset,
  palette_editor_if.slave  bus
);

  localparam logic [8:0] c_STEP9 = 9'(STEP);

  typedef enum logic [1:0] {
    S_LOAD_REQ = 2'd0,
    S_LOAD_CAP = 2'd1,
    S_EDIT     = 2'd2,
    S_WRITE    = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [23:0]       r_color;
  logic [1:0]        r_chan;
  logic              r_dirty;
  logic              r_wren;
  logic              r_busy;
`ifdef PALETTE_AUTOCOMMIT_EN
  logic [ADDR_W-1:0] r_tgt;   // index to load once the automatic write completes
  logic              r_auto;  // current WRITE was caused by an index change
`endif

  logic [ADDR_W-1:0] w_inc_idx;
  logic [ADDR_W-1:0] w_dec_idx;
  logic [ADDR_W-1:0] w_tgt_idx;
  logic              w_idx_move;
  logic              w_adj;
  logic [7:0]        w_cur;
  logic [8:0]        w_sum;
  logic [7:0]        w_new_ch;
  logic [23:0]       w_new_color;
  logic              w_changed;

  // Index arithmetic wraps naturally at the ADDR_W boundary
  assign w_inc_idx  = r_idx + 1'b1;
  assign w_dec_idx  = r_idx - 1'b1;
  assign w_tgt_idx  = bus.next_entry ? w_inc_idx : w_dec_idx;
  assign w_idx_move = bus.next_entry ^ bus.prev_entry;
  assign w_adj      = bus.inc ^ bus.dec;
  assign w_sum      = {1'b0, w_cur} + c_STEP9;
  assign w_changed  = (w_new_ch != w_cur);

  // Saturating adjustment of the selected channel, other channels pass through
  always_comb begin
    w_cur       = r_color[7:0];
    w_new_ch    = w_cur;
    w_new_color = r_color;
    case (r_chan)
      2'd0:    w_cur = r_color[23:16];
      2'd1:    w_cur = r_color[15:8];
      default: w_cur = r_color[7:0];
    endcase
    if (bus.inc) begin
      w_new_ch = w_sum[8] ? 8'hFF : w_sum[7:0];
    end else if ({1'b0, w_cur} < c_STEP9) begin
      w_new_ch = 8'h00;
    end else begin
      w_new_ch = w_cur - c_STEP9[7:0];
    end
    case (r_chan)
      2'd0:    w_new_color[23:16] = w_new_ch;
      2'd1:    w_new_color[15:8]  = w_new_ch;
      default: w_new_color[7:0]   = w_new_ch;
    endcase
  end

  // Load / edit / write-back state machine with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_LOAD_REQ;
      r_idx   <= '0;
      r_color <= '0;
      r_chan  <= 2'd0;
      r_dirty <= 1'b0;
      r_wren  <= 1'b0;
      r_busy  <= 1'b1;
`ifdef PALETTE_AUTOCOMMIT_EN
      r_tgt   <= '0;
      r_auto  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_LOAD_REQ: begin
          r_state <= S_LOAD_CAP;
        end
        S_LOAD_CAP: begin
          r_color <= bus.ram_rdata;
          r_dirty <= 1'b0;
          r_state <= S_EDIT;
          r_busy  <= 1'b0;
        end
        S_EDIT: begin
          if (bus.commit) begin
            r_state <= S_WRITE;
            r_wren  <= 1'b1;
            r_busy  <= 1'b1;
          end else if (w_idx_move) begin
            r_busy <= 1'b1;
`ifdef PALETTE_AUTOCOMMIT_EN
            if (r_dirty) begin
              r_tgt   <= w_tgt_idx;
              r_auto  <= 1'b1;
              r_wren  <= 1'b1;
              r_state <= S_WRITE;
            end else begin
              r_idx   <= w_tgt_idx;
              r_state <= S_LOAD_REQ;
            end
`else
            r_idx   <= w_tgt_idx;
            r_state <= S_LOAD_REQ;
`endif
          end else if (bus.chan_next) begin
            r_chan <= (r_chan == 2'd2) ? 2'd0 : r_chan + 2'd1;
          end else if (w_adj && w_changed) begin
            r_color <= w_new_color;
            r_dirty <= 1'b1;
          end
        end
        S_WRITE: begin
          r_wren  <= 1'b0;
          r_dirty <= 1'b0;
`ifdef PALETTE_AUTOCOMMIT_EN
          if (r_auto) begin
            r_auto  <= 1'b0;
            r_idx   <= r_tgt;
            r_state <= S_LOAD_REQ;
          end else begin
            r_state <= S_EDIT;
            r_busy  <= 1'b0;
          end
`else
          r_state <= S_EDIT;
          r_busy  <= 1'b0;
`endif
        end
        default: begin
          r_state <= S_LOAD_REQ;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ram_addr   = r_idx;
  assign bus.ram_wdata  = r_color;
  assign bus.ram_wren   = r_wren;
  assign bus.entry_idx  = r_idx;
  assign bus.edit_color = r_color;
  assign bus.chan       = r_chan;
  assign bus.dirty      = r_dirty;
  assign bus.busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_palette_editor.sv
// ============================================================================
//  Module      : tb_palette_editor
//  Description : Self-checking bench for palette_editor with a behavioural
//                palette RAM and a write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_palette_editor;

`ifdef PALETTE_AUTOCOMMIT_EN
  localparam bit c_AC = 1'b1;
`else
  localparam bit c_AC = 1'b0;
`endif

  // Button encoding {next, prev, chan_next, inc, dec, commit}
  localparam logic [5:0] NX = 6'b100000;
  localparam logic [5:0] PV = 6'b010000;
  localparam logic [5:0] CN = 6'b001000;
  localparam logic [5:0] IC = 6'b000100;
  localparam logic [5:0] DC = 6'b000010;
  localparam logic [5:0] CM = 6'b000001;

  localparam logic [23:0] c_E23 = c_AC ? 24'h223222 : 24'h222A22;
  localparam logic [23:0] c_E25 = c_AC ? 24'h22321A : 24'h222A1A;

  typedef struct {
    logic [5:0]  btn;
    logic [3:0]  idx;
    logic [23:0] col;
    logic [1:0]  ch;
    logic        dt;
    logic        wr;
    logic [3:0]  wa;
    logic [23:0] wd;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [23:0] mem [16];
  logic [27:0] sb [$];
  vec_t        tv [$];

  palette_editor_if #(.ADDR_W(4)) bus ();

  palette_editor #(.ADDR_W(4), .STEP(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Palette RAM: registered read, write on enable
  always @(posedge clk) begin
    bus.ram_rdata <= mem[bus.ram_addr];
    if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Each cycle with ram_wren high must match the oldest expected write
  always @(negedge clk) begin
    if (bus.ram_wren === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected actual=%h/%h required=none", bus.ram_addr, bus.ram_wdata);
      end else begin
        chk("wr_addr_data", {bus.ram_addr, bus.ram_wdata}, {4'h0, sb.pop_front()});
      end
    end
  end

  task automatic set_btn(input logic [5:0] b);
    {bus.next_entry, bus.prev_entry, bus.chan_next, bus.inc, bus.dec, bus.commit} = b;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 16; i++) begin
      if (bus.busy === 1'b0) break;
      @(negedge clk);
    end
    if (bus.busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=%b required=0", bus.busy);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] idx, input logic [23:0] col,
                             input logic [1:0] ch, input logic dt);
    chk({tag, "_idx"},   bus.entry_idx,  idx);
    chk({tag, "_color"}, bus.edit_color, col);
    chk({tag, "_chan"},  bus.chan,       ch);
    chk({tag, "_dirty"}, bus.dirty,      dt);
  endtask

  task automatic apply(input vec_t v, input int n);
    if (v.wr) sb.push_back({v.wa, v.wd});
    @(negedge clk);
    set_btn(v.btn);
    @(negedge clk);
    set_btn(6'b0);
    wait_idle();
    check_state($sformatf("vec%0d", n), v.idx, v.col, v.ch, v.dt);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) mem[k] = 24'h111111 * k;
    set_btn(6'b0);

    tv.push_back('{PV,      4'd15, 24'hFFFFFF, 2'd0, 1'b0, 1'b0, 4'd0,  24'h0});
    tv.push_back('{NX,      4'd0,  24'h000000, 2'd0, 1'b0, 1'b0, 4'd0,  24'h0});
    tv.push_back('{PV,      4'd15, 24'hFFFFFF, 2'd0, 1'b0, 1'b0, 4'd0,  24'h0});
    tv.push_back('{IC,      4'd15, 24'hFFFFFF, 2'd0, 1'b0, 1'b0, 4'd0,  24'h0});
    tv.push_back('{DC,      4'd15, 24'hF7FFFF, 2'd0, 1'b1, 1'b0, 4'd0,  24'h0});
    tv.push_back('{DC,      4'd15, 24'hEFFFFF, 2'd0, 1'b1, 1'b0, 4'd0,  24'h0});
    tv.push_back('{CN,      4'd15, 24'hEFFFFF, 2'd1, 1'b1, 1'b0, 4'd0,  24'h0});
    tv.push_back('{CN,      4'd15, 24'hEFFFFF, 2'd2, 1'b1, 1'b0, 4'd0,  24'h0});
    tv.push_back('{CN,      4'd15, 24'hEFFFFF, 2'd0, 1'b1, 1'b0, 4'd0,  24'h0});
    tv.push_back('{NX,      4'd0,  24'h000000, 2'd0, 1'b0, c_AC, 4'd15, 24'hEFFFFF});
    tv.push_back('{DC,      4'd0,  24'h000000, 2'd0, 1'b0, 1'b0, 4'd0,  24'h0});
    tv.push_back('{NX,      4'd1,  24'h111111, 2'd0, 1'b0, 1'b0, 4'd0,  24'h0});
    tv.push_back('{NX,      4'd2,  24'h222222, 2'd0, 1'b0, 1'b0, 4'd0,  24'h0});
    tv.push_back('{CN,      4'd2,  24'h222222, 2'd1, 1'b0, 1'b0, 4'd0,  24'h0});
    tv.push_back('{IC,      4'd2,  24'h222A22, 2'd1, 1'b1, 1'b0, 4'd0,  24'h0});
    tv.push_back('{CM,      4'd2,  24'h222A22, 2'd1, 1'b0, 1'b1, 4'd2,  24'h222A22});
    tv.push_back('{PV,      4'd1,  24'h111111, 2'd1, 1'b0, 1'b0, 4'd0,  24'h0});
    tv.push_back('{NX,      4'd2,  24'h222A22, 2'd1, 1'b0, 1'b0, 4'd0,  24'h0});
    tv.push_back('{IC | DC, 4'd2,  24'h222A22, 2'd1, 1'b0, 1'b0, 4'd0,  24'h0});
    tv.push_back('{CM | NX, 4'd2,  24'h222A22, 2'd1, 1'b0, 1'b1, 4'd2,  24'h222A22});
    tv.push_back('{IC,      4'd2,  24'h223222, 2'd1, 1'b1, 1'b0, 4'd0,  24'h0});
    tv.push_back('{NX,      4'd3,  24'h333333, 2'd1, 1'b0, c_AC, 4'd2,  24'h223222});
    tv.push_back('{PV,      4'd2,  c_E23,      2'd1, 1'b0, 1'b0, 4'd0,  24'h0});
    tv.push_back('{CN,      4'd2,  c_E23,      2'd2, 1'b0, 1'b0, 4'd0,  24'h0});
    tv.push_back('{DC,      4'd2,  c_E25,      2'd2, 1'b1, 1'b0, 4'd0,  24'h0});

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b1);
    chk("rst_wren", bus.ram_wren, 1'b0);
    check_state("rst", 4'd0, 24'h0, 2'd0, 1'b0);

    // Load latency after reset release: still busy after 1 clk, idle after 2
    reset = 1'b0;
    @(negedge clk);
    chk("load_busy_1clk", bus.busy, 1'b1);
    @(negedge clk);
    chk("load_busy_2clk", bus.busy, 1'b0);
    check_state("load0", 4'd0, 24'h000000, 2'd0, 1'b0);

    // Pulses while busy are dropped (inc and commit during the reload)
    @(negedge clk);
    set_btn(NX);
    @(negedge clk);
    set_btn(IC | CM);
    @(negedge clk);
    set_btn(6'b0);
    wait_idle();
    check_state("busy_drop", 4'd1, 24'h111111, 2'd0, 1'b0);
    apply('{PV, 4'd0, 24'h000000, 2'd0, 1'b0, 1'b0, 4'd0, 24'h0}, 99);

    foreach (tv[i]) apply(tv[i], i);

    // Reset asserted during WRITE aborts the write at once
    sb.push_back({4'd2, c_E25});
    @(negedge clk);
    set_btn(CM);
    @(negedge clk);
    set_btn(6'b0);
    chk("wr_pulse_high", bus.ram_wren, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("abort_wren", bus.ram_wren, 1'b0);
    chk("abort_idx", bus.entry_idx, 4'd0);
    chk("abort_busy", bus.busy, 1'b1);
    @(negedge clk);
    chk("abort_mem2", mem[2], c_E23);
    reset = 1'b0;
    @(negedge clk);
    wait_idle();
    check_state("after_abort", 4'd0, 24'h000000, 2'd0, 1'b0);

    chk("wr_pending", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
